ov7670_read: RTL and testbench

- Capture block for an OV7670 camera running in YUV422 (two bytes per pixel) at VGA, 640x480.
- Extracts the luma byte of each pixel and binarizes it against a threshold.
- Stores one bit per pixel in an internal frame buffer and offers a random-access read port.
- Sits between the camera parallel bus and downstream image-processing logic; all logic runs on the camera pixel clock.

---
 rtl/ov7670_read_if.sv | 44 ++++
 rtl/ov7670_read.sv | 186 ++++++++++++++++++
 tb/tb_ov7670_read.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_read_if.sv
// ---------------------------------------------------------------------------
// ov7670_read_if
//
// Purpose:
//   Groups the OV7670 parallel camera bus and the frame-buffer read port that
//   connect to the ov7670_read capture block. Signal names keep the
//   direction they have at the capture block (i_ = into it, o_ = out of it).
//
// Signals:
//   i_vsync      camera vertical sync (1 = vertical blank, 0 = frame active)
//   i_href       camera line valid (1 while a line's bytes are on i_d)
//   i_d[7:0]     camera data byte, one byte per pixel clock
//   i_readAddr   pixel address to read, row*WIDTH+col
//   o_bufferData binarized pixel at i_readAddr, one clock later
//
// Modports:
//   master  camera / downstream side (drives the bus, reads o_bufferData)
//   slave   the capture block
// ---------------------------------------------------------------------------
interface ov7670_read_if #(
    parameter int ADDR_W = 19
);
    logic              i_vsync;
    logic              i_href;
    logic [7:0]        i_d;
    logic [ADDR_W-1:0] i_readAddr;
    logic              o_bufferData;

    modport master (
        output i_vsync,
        output i_href,
        output i_d,
        output i_readAddr,
        input  o_bufferData
    );

    modport slave (
        input  i_vsync,
        input  i_href,
        input  i_d,
        input  i_readAddr,
        output o_bufferData
    );
endinterface

// File: rtl/ov7670_read.sv
// ---------------------------------------------------------------------------
// ov7670_read
//
// Purpose:
//   Captures YUV422 frames from an OV7670 camera, keeps only the luma byte of
//   each pixel, binarizes it against THRESHOLD and stores one bit per pixel in
//   an internal WIDTH*HEIGHT x 1 frame buffer. A registered random-access
//   read port returns the stored bit one pixel clock after the address is
//   applied. Everything runs on the camera pixel clock.
//
// Ports:
//   i_pclk       camera pixel clock, rising edge
//   i_reset      synchronous active-high reset
//   bus          ov7670_read_if slave modport (VSYNC, HREF, D, ReadAddr,
//                BufferData)
//   o_frameDone  (only with OV7670_FRAME_DONE_EN) one-clock pulse when a
//                complete frame (HEIGHT lines captured) is closed by VSYNC
//
// Build option:
//   OV7670_FRAME_DONE_EN  define to add o_frameDone and its logic.
//
// Parameters:
//   WIDTH, HEIGHT  active frame size in pixels / lines
//   ADDR_W         buffer address width, 2**ADDR_W >= WIDTH*HEIGHT
//   THRESHOLD      luma value at or above which the stored bit is 1
//   LUMA_PHASE     byte within a pixel (0 or 1) that carries luma
// ---------------------------------------------------------------------------
module ov7670_read #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int THRESHOLD  = 128,
    parameter int LUMA_PHASE = 0
) (
    input  logic         i_pclk,
    input  logic         i_reset,
    ov7670_read_if.slave bus
`ifdef OV7670_FRAME_DONE_EN
    ,
    output logic         o_frameDone
`endif
);

    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int COL_W  = $clog2(WIDTH + 1);
    localparam int ROW_W  = $clog2(HEIGHT + 1);

    localparam logic [COL_W-1:0]  WIDTH_C   = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0]  HEIGHT_R  = ROW_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [8:0]        THRESH_9  = 9'(THRESHOLD);
    localparam logic              LUMA_BIT  = 1'(LUMA_PHASE);

    logic              r_vsyncPrev;
    logic              r_hrefPrev;
    logic              r_armed;
    logic              r_phase;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [ADDR_W-1:0] r_lineBase;
    logic              r_bufferData;

    logic              r_mem [0:DEPTH-1];

    logic w_vsyncFall;
    logic w_vsyncRise;
    logic w_hrefFall;
    logic w_active;
    logic w_colOk;
    logic w_rowOk;
    logic w_we;
    logic w_pixelBit;
    logic w_readInRange;

    // Edge detectors on the camera syncs, and the "this byte belongs to an
    // armed active line" qualifier everything else is built on.
    assign w_vsyncFall   = r_vsyncPrev & ~bus.i_vsync;
    assign w_vsyncRise   = ~r_vsyncPrev & bus.i_vsync;
    assign w_hrefFall    = r_hrefPrev & ~bus.i_href;
    assign w_active      = r_armed & ~bus.i_vsync & bus.i_href;
    assign w_colOk       = (r_col < WIDTH_C);
    assign w_rowOk       = (r_row < HEIGHT_R);
    assign w_pixelBit    = ({1'b0, bus.i_d} >= THRESH_9);
    assign w_readInRange = ({1'b0, bus.i_readAddr} < DEPTH_X);

    // Reset is folded into the write enable so a reset in the middle of a
    // line stops capture on the very cycle it is sampled.
    assign w_we = ~i_reset & w_active & (r_phase == LUMA_BIT) & w_colOk & w_rowOk;

    // Capture control. The write address is kept incrementally: it advances
    // with the column counter, and at each line end it jumps to the start of
    // the next line (r_lineBase + WIDTH), so short or over-long lines always
    // land the next line at row*WIDTH without a multiplier. Row and column
    // saturate at HEIGHT/WIDTH, which is what drops surplus pixels and lines.
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_vsyncPrev <= 1'b0;
            r_hrefPrev  <= 1'b0;
            r_armed     <= 1'b0;
            r_phase     <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_wrAddr    <= '0;
            r_lineBase  <= '0;
        end else begin
            r_vsyncPrev <= bus.i_vsync;
            r_hrefPrev  <= bus.i_href;

            if (w_vsyncFall) begin
                r_armed    <= 1'b1;
                r_phase    <= 1'b0;
                r_col      <= '0;
                r_row      <= '0;
                r_wrAddr   <= '0;
                r_lineBase <= '0;
            end else begin
                if (w_vsyncRise) begin
                    r_armed <= 1'b0;
                end

                // Phase only runs inside an armed active line; any gap in
                // HREF realigns it so an odd byte count cannot skew the
                // next line.
                r_phase <= w_active ? ~r_phase : 1'b0;

                if (w_active && r_phase && w_colOk) begin
                    r_col    <= r_col + COL_W'(1);
                    r_wrAddr <= r_wrAddr + ADDR_W'(1);
                end

                if (w_hrefFall && r_armed && !bus.i_vsync) begin
                    r_col <= '0;
                    if (w_rowOk) begin
                        r_row      <= r_row + ROW_W'(1);
                        r_lineBase <= r_lineBase + WIDTH_A;
                        r_wrAddr   <= r_lineBase + WIDTH_A;
                    end
                end
            end
        end
    end

    // Frame-buffer write port. Kept free of reset so it maps onto block RAM;
    // the buffer contents deliberately survive a reset.
    always_ff @(posedge i_pclk) begin
        if (w_we) begin
            r_mem[r_wrAddr[MEM_AW-1:0]] <= w_pixelBit;
        end
    end

    // Registered read port. Non-blocking read against the write above gives
    // read-first behaviour when both hit the same address in one cycle.
    // Addresses past the end of the frame read as 0.
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_bufferData <= 1'b0;
        end else if (w_readInRange) begin
            r_bufferData <= r_mem[bus.i_readAddr[MEM_AW-1:0]];
        end else begin
            r_bufferData <= 1'b0;
        end
    end

    assign bus.o_bufferData = r_bufferData;

`ifdef OV7670_FRAME_DONE_EN
    logic r_frameDone;

    // A frame counts as done only if it was armed and every one of its
    // HEIGHT lines ended before VSYNC rose; reset clears r_armed, so a frame
    // cut short by reset never pulses.
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_vsyncRise & r_armed & (r_row == HEIGHT_R);
        end
    end

    assign o_frameDone = r_frameDone;
`endif

endmodule

// File: tb/tb_ov7670_read.sv
// ---------------------------------------------------------------------------
// tb_ov7670_read
//
// Purpose:
//   Self-checking bench for ov7670_read, using a reduced 32x12 frame so whole
//   frames fit in a short run. A behavioural frame model (an array indexed
//   row*W+col, updated from the byte stream the bench itself drives) supplies
//   expected read data. A fixed vector table covers the threshold boundary,
//   read latency and out-of-range reads; hand-written sequences cover
//   read-first, long lines, sync gating and mid-frame reset; randomized
//   frames are then swept against the model.
// ---------------------------------------------------------------------------
module tb_ov7670_read;

    localparam int W     = 32;
    localparam int H     = 12;
    localparam int AW    = 9;
    localparam int TH    = 128;
    localparam int LP    = 0;
    localparam int DEPTH = W * H;
    localparam int BLANK = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ov7670_read_if #(.ADDR_W(AW)) bus ();

`ifdef OV7670_FRAME_DONE_EN
    logic frameDone;
    int   fdCount = 0;
`endif

    ov7670_read #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .ADDR_W     (AW),
        .THRESHOLD  (TH),
        .LUMA_PHASE (LP)
    ) dut (
        .i_pclk      (clk),
        .i_reset     (reset),
        .bus         (bus)
`ifdef OV7670_FRAME_DONE_EN
        ,
        .o_frameDone (frameDone)
`endif
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

`ifdef OV7670_FRAME_DONE_EN
    // Count every high sample of FrameDone, away from the active edge.
    always @(negedge clk) begin
        if (frameDone === 1'b1) fdCount++;
    end
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural picture of the frame buffer plus capture state.
    bit   modelMem [DEPTH];
    bit   modelArmed = 1'b0;
    int   modelRow   = 0;
    logic [7:0] lineBuf [$];

    typedef struct {
        int    addr;
        bit    exp;
        string name;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Apply a read address and check the data one clock later.
    task automatic applyStimulus(input int addr, input bit expected, input string name);
        bus.i_readAddr = AW'(addr);
        tick();
        checkOutput(name, 32'(bus.o_bufferData), 32'(expected));
    endtask

    task automatic frameStart();
`ifdef OV7670_FRAME_DONE_EN
        fdCount = 0;
`endif
        bus.i_vsync = 1'b0;
        repeat (4) tick();
        modelArmed = 1'b1;
        modelRow   = 0;
    endtask

    task automatic frameEnd();
        bus.i_vsync = 1'b1;
        repeat (4) tick();
        modelArmed = 1'b0;
    endtask

    // Build one line of nPix pixels into lineBuf.
    // mode 0: luma 255 on even columns, 0 on odd; 1: all 255; 2: all 0;
    // 3: random luma; 4: luma 0 on even columns, 255 on odd.
    task automatic buildLine(input int nPix, input int mode);
        logic [7:0] luma;
        logic [7:0] chroma;
        lineBuf.delete();
        for (int p = 0; p < nPix; p++) begin
            case (mode)
                0:       luma = (p % 2 == 0) ? 8'd255 : 8'd0;
                1:       luma = 8'd255;
                2:       luma = 8'd0;
                4:       luma = (p % 2 == 1) ? 8'd255 : 8'd0;
                default: luma = 8'($urandom_range(255));
            endcase
            chroma = 8'($urandom_range(255));
            if (LP == 0) begin
                lineBuf.push_back(luma);
                lineBuf.push_back(chroma);
            end else begin
                lineBuf.push_back(chroma);
                lineBuf.push_back(luma);
            end
        end
    endtask

    // Drive lineBuf as one HREF line and update the model from the rules:
    // byte i is pixel i/2, luma when i%2 == LP, kept only inside the frame.
    task automatic sendLine();
        int n;
        n = lineBuf.size();
        for (int i = 0; i < n; i++) begin
            bus.i_href = 1'b1;
            bus.i_d    = lineBuf[i];
            if (modelArmed && bus.i_vsync == 1'b0 && modelRow < H &&
                (i % 2) == LP && (i / 2) < W) begin
                modelMem[modelRow * W + i / 2] = (lineBuf[i] >= TH);
            end
            tick();
        end
        bus.i_href = 1'b0;
        bus.i_d    = 8'd0;
        if (n > 0 && modelArmed && bus.i_vsync == 1'b0 && modelRow < H) modelRow++;
        repeat (BLANK) tick();
    endtask

    task automatic sweepAll(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(a, modelMem[a], $sformatf("%s[%0d]", tag, a));
        end
    endtask

    initial begin
        int nLines;
        int kReset;

        vecs[0] = '{0,       1'b1, "px0_luma200"};
        vecs[1] = '{1,       1'b0, "px1_luma10"};
        vecs[2] = '{2,       1'b1, "px2_luma128"};
        vecs[3] = '{3,       1'b0, "px3_luma127"};
        vecs[4] = '{4,       1'b1, "px4_untouched"};
        vecs[5] = '{DEPTH,   1'b0, "oob_depth"};
        vecs[6] = '{W,       1'b1, "row1_untouched"};
        vecs[7] = '{511,     1'b0, "oob_max"};
        vecs[8] = '{W + 1,   1'b0, "row1_col1"};

        bus.i_vsync    = 1'b1;
        bus.i_href     = 1'b0;
        bus.i_d        = 8'd0;
        bus.i_readAddr = '0;

        // Reset held two cycles with VSYNC high.
        reset = 1'b1;
        tick();
        checkOutput("reset_bufferData_c1", 32'(bus.o_bufferData), 32'd0);
        tick();
        checkOutput("reset_bufferData_c2", 32'(bus.o_bufferData), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Full frame, luma 255 on even columns and 0 on odd.
        frameStart();
        for (int r = 0; r < H; r++) begin
            buildLine(W, 0);
            sendLine();
        end
        frameEnd();
`ifdef OV7670_FRAME_DONE_EN
        checkOutput("frameDone_full", 32'(fdCount), 32'd1);
`endif
        applyStimulus(0,           1'b1, "full_addr0");
        applyStimulus(1,           1'b0, "full_addr1");
        applyStimulus(DEPTH - 1,   1'b0, "full_last");
        applyStimulus((H - 1) * W, 1'b1, "full_lastRowStart");

        // One short line with threshold-boundary lumas, then the vector table.
        frameStart();
        lineBuf.delete();
        lineBuf.push_back(8'd200); lineBuf.push_back(8'd55);
        lineBuf.push_back(8'd10);  lineBuf.push_back(8'd250);
        lineBuf.push_back(8'd128); lineBuf.push_back(8'd3);
        lineBuf.push_back(8'd127); lineBuf.push_back(8'd200);
        sendLine();
        frameEnd();
`ifdef OV7670_FRAME_DONE_EN
        checkOutput("frameDone_oneLine", 32'(fdCount), 32'd0);
`endif
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].exp, vecs[v].name);
        end

        // Read-first: read address 0 while pixel 0 (currently 1) is written 0.
        bus.i_readAddr = '0;
        frameStart();
        bus.i_href = 1'b1;
        bus.i_d    = 8'd0;
        tick();
        checkOutput("read_first_old", 32'(bus.o_bufferData), 32'd1);
        bus.i_d    = 8'd99;
        tick();
        checkOutput("read_after_write", 32'(bus.o_bufferData), 32'd0);
        modelMem[0] = 1'b0;
        bus.i_href = 1'b0;
        repeat (BLANK) tick();
        frameEnd();

        // Over-long line (W+5 pixels, all 255) then a line of 0,255,0,...
        frameStart();
        buildLine(W + 5, 1);
        sendLine();
        buildLine(W, 4);
        sendLine();
        frameEnd();
`ifdef OV7670_FRAME_DONE_EN
        checkOutput("frameDone_truncated", 32'(fdCount), 32'd0);
`endif
        applyStimulus(W - 1, 1'b1, "long_lastCol");
        applyStimulus(W,     1'b0, "long_nextRow0");
        applyStimulus(W + 1, 1'b1, "long_nextRow1");
        applyStimulus(2 * W, 1'b1, "long_row2_untouched");

        // HREF pulses while VSYNC is high must change nothing.
        buildLine(W, 1);
        sendLine();
        buildLine(W, 2);
        sendLine();

        // Reset in the middle of a line; capture stops at once and stays
        // off until the next VSYNC falling edge.
        frameStart();
        buildLine(W, 3);
        sendLine();
        buildLine(W, 3);
        kReset = 10;
        bus.i_readAddr = AW'(2 * W);
        for (int i = 0; i < lineBuf.size(); i++) begin
            bus.i_href = 1'b1;
            bus.i_d    = lineBuf[i];
            if (i == kReset) begin
                reset      = 1'b1;
                modelArmed = 1'b0;
            end
            if (i == kReset + 2) reset = 1'b0;
            if (modelArmed && (i % 2) == LP && (i / 2) < W) begin
                modelMem[modelRow * W + i / 2] = (lineBuf[i] >= TH);
            end
            tick();
            if (i == kReset) begin
                checkOutput("midReset_bufferData", 32'(bus.o_bufferData), 32'd0);
            end
        end
        bus.i_href = 1'b0;
        repeat (BLANK) tick();
        buildLine(W, 3);
        sendLine();
        buildLine(W, 3);
        sendLine();
        frameEnd();
`ifdef OV7670_FRAME_DONE_EN
        checkOutput("frameDone_afterReset", 32'(fdCount), 32'd0);
`endif
        sweepAll("afterReset");

        // Randomized frames: random line counts and lengths, random luma.
        for (int f = 0; f < 3; f++) begin
            nLines = (f == 0) ? H + 2 : $urandom_range(H + 2, 1);
            frameStart();
            for (int r = 0; r < nLines; r++) begin
                buildLine($urandom_range(W + 4, 1), 3);
                sendLine();
            end
            frameEnd();
`ifdef OV7670_FRAME_DONE_EN
            checkOutput($sformatf("frameDone_rand%0d", f), 32'(fdCount),
                        (nLines >= H) ? 32'd1 : 32'd0);
`endif
            sweepAll($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
